// File: rtl/complex_fir_coeff_loader.sv
// Multi-bank complex coefficient RAM with a valid/ready tap streamer for the complex FIR load port.
// Optional feature: define COEFF_CONJUGATE_EN to add a per-stream saturating conjugate of Im.
`timescale 1ns/1ps
module complex_fir_coeff_loader #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 18,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int BANK_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wrEnable,
  input  logic [BANK_WIDTH-1:0] wrBank,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrDataRe,
  input  logic [DATA_WIDTH-1:0] wrDataIm,
  input  logic                  loadStart,
  input  logic [BANK_WIDTH-1:0] loadBank,
`ifdef COEFF_CONJUGATE_EN
  input  logic                  conjugate,
`endif
  input  logic                  coeffReady,
  output logic                  coeffValid,
  output logic [DATA_WIDTH-1:0] coeffOutRe,
  output logic [DATA_WIDTH-1:0] coeffOutIm,
  output logic                  coeffLast,
  output logic                  coeffSetFlag,
  output logic                  busy,
  output logic                  error
);

  localparam int MEM_DEPTH = NUM_BANKS * LENGTH;
  localparam int MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]      LEN_LIM  = CNT_W'(LENGTH);
  localparam logic [CNT_W-1:0]      LAST_IDX = CNT_W'(LENGTH - 1);
  localparam logic [BANK_WIDTH:0]   BANK_LIM = (BANK_WIDTH + 1)'(NUM_BANKS);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
  state_t state_reg, state_next;

  logic [2*DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [2*DATA_WIDTH-1:0] rd_data_reg;
  logic [BANK_WIDTH-1:0]   bank_reg;
  logic [CNT_W-1:0]        issue_reg;
  logic                    valid_reg;
  logic                    last_reg;
  logic                    flag_reg;
  logic                    error_reg;

  logic              wr_accept, wr_reject;
  logic              start_accept, start_reject;
  logic              handshake, last_xfer, fetch;
  logic [MEM_AW-1:0] wr_index, rd_index;
  logic signed [DATA_WIDTH-1:0] im_raw, im_eff;

  assign wr_accept = wrEnable
                   && ({1'b0, wrBank} < BANK_LIM)
                   && ({1'b0, wrAddr} < LEN_LIM)
                   && !((state_reg == ST_LOAD) && (wrBank == bank_reg));
  assign wr_reject = wrEnable && !wr_accept;

  assign start_accept = loadStart && (state_reg != ST_LOAD) && ({1'b0, loadBank} < BANK_LIM);
  assign start_reject = loadStart && !start_accept;

  assign handshake = valid_reg && coeffReady;
  assign last_xfer = handshake && last_reg;
  // Refill the output register whenever it is empty or being drained, so taps flow at one per cycle.
  assign fetch = (state_reg == ST_LOAD) && (!valid_reg || coeffReady) && (issue_reg < LEN_LIM);

  assign wr_index = MEM_AW'(int'(wrBank) * LENGTH + int'(wrAddr));
  assign rd_index = MEM_AW'(int'(bank_reg) * LENGTH + int'(issue_reg));

  // RAM has no reset; the read register doubles as the output holding register under backpressure.
  always_ff @(posedge clock) begin
    if (wr_accept) begin
      mem[wr_index] <= {wrDataRe, wrDataIm};
    end
    if (fetch) begin
      rd_data_reg <= mem[rd_index];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (start_accept) state_next = ST_LOAD;
      ST_LOAD:          if (last_xfer) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_reg  <= '0;
      issue_reg <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      flag_reg  <= 1'b0;
      error_reg <= 1'b0;
    end else begin
      error_reg <= wr_reject || start_reject;
      if (start_accept) begin
        bank_reg  <= loadBank;
        issue_reg <= '0;
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
        flag_reg  <= 1'b0;
      end else if (state_reg == ST_LOAD) begin
        if (last_xfer) begin
          valid_reg <= 1'b0;
          last_reg  <= 1'b0;
          flag_reg  <= 1'b1;
        end else if (fetch) begin
          valid_reg <= 1'b1;
          last_reg  <= (issue_reg == LAST_IDX);
          issue_reg <= issue_reg + 1'b1;
        end
      end
    end
  end

  assign im_raw = rd_data_reg[DATA_WIDTH-1:0];

`ifdef COEFF_CONJUGATE_EN
  localparam logic signed [DATA_WIDTH-1:0] IM_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] IM_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  logic conj_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      conj_reg <= 1'b0;
    end else if (start_accept) begin
      conj_reg <= conjugate;
    end
  end

  // The most negative value has no positive twin, so it saturates.
  assign im_eff = !conj_reg ? im_raw : ((im_raw == IM_MIN) ? IM_MAX : -im_raw);
`else
  assign im_eff = im_raw;
`endif

  assign coeffValid   = valid_reg;
  assign coeffLast    = last_reg;
  assign coeffOutRe   = valid_reg ? rd_data_reg[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign coeffOutIm   = valid_reg ? im_eff : '0;
  assign coeffSetFlag = flag_reg;
  assign busy         = (state_reg == ST_LOAD);
  assign error        = error_reg;

endmodule
